// File: rtl/fifo_access_arbiter.sv
// Arbiter/sequencer in front of the output FIFO: picks at most one write (A/B round-robin)
// or read per cycle, registers the FIFO strobes, tracks occupancy and reports the state code.
module fifo_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  input  logic                  rd_req,
  output logic                  fifo_wr_en,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  data_count,
  output logic                  gnt_a,
  output logic                  gnt_b,
  output logic                  err_a,
  output logic                  err_b,
  output logic                  rd_gnt,
  output logic                  rd_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    WR_ERROR = 3'b011,
    RD_ERROR = 3'b100
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic                  err_a_q, err_a_d, err_b_q, err_b_d;
  logic                  rd_gnt_q, rd_gnt_d, rd_err_q, rd_err_d;
  logic                  pend_a_q, pend_a_d, pend_b_q, pend_b_d, pend_r_q, pend_r_d;
  // last_w_q = 1 means A was the last writer served, so B wins the next A/B tie.
  logic                  last_w_q, last_w_d;
  logic                  rw_pri_q, rw_pri_d;

  logic eff_a, eff_b, eff_r, eff_w, sel_b;
  logic wr_ok, rd_ok, wr_legal, rd_legal, pick_rd;

  assign eff_a    = req_a | pend_a_q;
  assign eff_b    = req_b | pend_b_q;
  assign eff_r    = rd_req | pend_r_q;
  assign eff_w    = eff_a | eff_b;
  assign sel_b    = eff_b & (~eff_a | last_w_q);
  assign wr_ok    = (count_q < CNT_WIDTH'(DEPTH));
  assign rd_ok    = (count_q != '0);
  assign wr_legal = eff_w & wr_ok;
  assign rd_legal = eff_r & rd_ok;
  assign pick_rd  = rd_legal & (~wr_legal | rw_pri_q);

  // Every effective request stays pending unless it is served or errored this cycle.
  always_comb begin
    state_d  = IDLE;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    din_d    = din_q;
    count_d  = count_q;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    err_a_d  = 1'b0;
    err_b_d  = 1'b0;
    rd_gnt_d = 1'b0;
    rd_err_d = 1'b0;
    pend_a_d = eff_a;
    pend_b_d = eff_b;
    pend_r_d = eff_r;
    last_w_d = last_w_q;
    rw_pri_d = rw_pri_q;

    if (wr_legal && rd_legal) begin
      rw_pri_d = ~rw_pri_q;
    end

    if (pick_rd) begin
      state_d  = READ;
      rd_en_d  = 1'b1;
      rd_gnt_d = 1'b1;
      pend_r_d = 1'b0;
      count_d  = count_q - CNT_WIDTH'(1);
    end else if (wr_legal) begin
      state_d  = WRITE;
      wr_en_d  = 1'b1;
      din_d    = sel_b ? din_b : din_a;
      count_d  = count_q + CNT_WIDTH'(1);
      last_w_d = ~sel_b;
      if (sel_b) begin
        gnt_b_d  = 1'b1;
        pend_b_d = 1'b0;
      end else begin
        gnt_a_d  = 1'b1;
        pend_a_d = 1'b0;
      end
    end else if (eff_w) begin
      state_d  = WR_ERROR;
      last_w_d = ~sel_b;
      if (sel_b) begin
        err_b_d  = 1'b1;
        pend_b_d = 1'b0;
      end else begin
        err_a_d  = 1'b1;
        pend_a_d = 1'b0;
      end
    end else if (eff_r) begin
      state_d  = RD_ERROR;
      rd_err_d = 1'b1;
      pend_r_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      din_q    <= '0;
      count_q  <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
      rd_gnt_q <= 1'b0;
      rd_err_q <= 1'b0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      pend_r_q <= 1'b0;
      last_w_q <= 1'b0;
      rw_pri_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      din_q    <= din_d;
      count_q  <= count_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      err_a_q  <= err_a_d;
      err_b_q  <= err_b_d;
      rd_gnt_q <= rd_gnt_d;
      rd_err_q <= rd_err_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      pend_r_q <= pend_r_d;
      last_w_q <= last_w_d;
      rw_pri_q <= rw_pri_d;
    end
  end

  assign state      = state_q;
  assign fifo_wr_en = wr_en_q;
  assign fifo_rd_en = rd_en_q;
  assign fifo_din   = din_q;
  assign data_count = count_q;
  assign gnt_a      = gnt_a_q;
  assign gnt_b      = gnt_b_q;
  assign err_a      = err_a_q;
  assign err_b      = err_b_q;
  assign rd_gnt     = rd_gnt_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter: hand-computed state/strobe/count vectors per cycle.
module tb_fifo_access_arbiter;

  localparam logic [2:0] S_IDLE = 3'b000, S_WRITE = 3'b001, S_READ = 3'b010,
                         S_WERR = 3'b011, S_RERR = 3'b100;
  localparam logic [7:0] F_NONE = 8'h00, F_WR = 8'h80, F_RD = 8'h40, F_GA = 8'h20,
                         F_GB = 8'h10, F_EA = 8'h08, F_EB = 8'h04, F_RG = 8'h02, F_RE = 8'h01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0, rd_req = 1'b0;
  logic [31:0] din_a = '0, din_b = '0;
  logic        fifo_wr_en, fifo_rd_en;
  logic [31:0] fifo_din;
  logic [2:0]  state;
  logic [5:0]  data_count;
  logic        gnt_a, gnt_b, err_a, err_b, rd_gnt, rd_err;

  int check_cnt = 0;
  int pass_cnt  = 0;

  fifo_access_arbiter #(.DATA_WIDTH(32), .DEPTH(32), .CNT_WIDTH(6)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .din_a(din_a), .req_b(req_b), .din_b(din_b), .rd_req(rd_req),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
    .state(state), .data_count(data_count),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .err_a(err_a), .err_b(err_b),
    .rd_gnt(rd_gnt), .rd_err(rd_err)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  // Packs {state, wr, rd, ga, gb, ea, eb, rg, re, count} into one comparable word.
  function automatic logic [31:0] dutVec();
    return {15'b0, state, fifo_wr_en, fifo_rd_en, gnt_a, gnt_b, err_a, err_b, rd_gnt, rd_err, data_count};
  endfunction

  function automatic logic [31:0] expVec(input logic [2:0] st, input logic [7:0] fl, input logic [5:0] cnt);
    return {15'b0, st, fl, cnt};
  endfunction

  // One-cycle strobes presented at the negedge, outputs observed #1 after the next posedge.
  task automatic applyStimulus(input logic a, input logic b, input logic r,
                               input logic [31:0] da, input logic [31:0] db);
    @(negedge clk);
    req_a = a; req_b = b; rd_req = r; din_a = da; din_b = db;
    @(posedge clk);
    #1;
    req_a = 1'b0; req_b = 1'b0; rd_req = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("reset_vec", dutVec(), expVec(S_IDLE, F_NONE, 6'd0));
    checkOutput("reset_din", fifo_din, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #2;
    checkOutput("por_vec", dutVec(), expVec(S_IDLE, F_NONE, 6'd0));
    @(negedge clk);
    reset = 1'b0;

    // Single write from A.
    applyStimulus(1, 0, 0, 32'hA5, 32'h0);
    checkOutput("wr_a_vec", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'd1));
    checkOutput("wr_a_din", fifo_din, 32'hA5);
    idleCycle();
    checkOutput("idle_after_wr", dutVec(), expVec(S_IDLE, F_NONE, 6'd1));

    // A/B tie from reset: A first; overlapping repeat sees B win, then pending A.
    doReset();
    applyStimulus(1, 1, 0, 32'h11, 32'h22);
    checkOutput("tie1_a", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'd1));
    checkOutput("tie1_a_din", fifo_din, 32'h11);
    applyStimulus(1, 1, 0, 32'h11, 32'h22);
    checkOutput("tie1_b_pend", dutVec(), expVec(S_WRITE, F_WR | F_GB, 6'd2));
    checkOutput("tie1_b_din", fifo_din, 32'h22);
    idleCycle();
    checkOutput("tie2_a_pend", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'd3));
    checkOutput("tie2_a_din", fifo_din, 32'h11);
    idleCycle();
    checkOutput("tie_idle", dutVec(), expVec(S_IDLE, F_NONE, 6'd3));
    applyStimulus(1, 1, 0, 32'h33, 32'h44);
    checkOutput("tie3_b_first", dutVec(), expVec(S_WRITE, F_WR | F_GB, 6'd4));
    checkOutput("tie3_b_din", fifo_din, 32'h44);
    idleCycle();
    checkOutput("tie3_a_next", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'd5));
    idleCycle();
    checkOutput("tie3_idle", dutVec(), expVec(S_IDLE, F_NONE, 6'd5));

    // Read/write conflicts at count 5 alternate priority.
    applyStimulus(1, 0, 1, 32'h55, 32'h0);
    checkOutput("rw1_write", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'd6));
    idleCycle();
    checkOutput("rw1_read", dutVec(), expVec(S_READ, F_RD | F_RG, 6'd5));
    applyStimulus(1, 0, 1, 32'h66, 32'h0);
    checkOutput("rw2_read", dutVec(), expVec(S_READ, F_RD | F_RG, 6'd4));
    idleCycle();
    checkOutput("rw2_write", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'd5));
    checkOutput("rw2_din", fifo_din, 32'h66);
    idleCycle();
    checkOutput("rw_idle", dutVec(), expVec(S_IDLE, F_NONE, 6'd5));

    // Back-to-back writes up to full.
    req_a = 1'b1; din_a = 32'h77;
    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      checkOutput("fill_vec", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'(6 + i)));
    end
    req_a = 1'b0;
    idleCycle();
    checkOutput("full_idle", dutVec(), expVec(S_IDLE, F_NONE, 6'd32));
    applyStimulus(0, 1, 0, 32'h0, 32'h88);
    checkOutput("full_err_b", dutVec(), expVec(S_WERR, F_EB, 6'd32));
    idleCycle();
    checkOutput("err_no_retry", dutVec(), expVec(S_IDLE, F_NONE, 6'd32));
    applyStimulus(0, 1, 1, 32'h0, 32'h99);
    checkOutput("full_read_wins", dutVec(), expVec(S_READ, F_RD | F_RG, 6'd31));
    idleCycle();
    checkOutput("full_b_after_rd", dutVec(), expVec(S_WRITE, F_WR | F_GB, 6'd32));
    checkOutput("full_b_din", fifo_din, 32'h99);

    // Drain to empty, then a read error.
    rd_req = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      checkOutput("drain_vec", dutVec(), expVec(S_READ, F_RD | F_RG, 6'(31 - i)));
    end
    rd_req = 1'b0;
    applyStimulus(0, 0, 1, 32'h0, 32'h0);
    checkOutput("empty_rd_err", dutVec(), expVec(S_RERR, F_RE, 6'd0));
    idleCycle();
    checkOutput("empty_idle", dutVec(), expVec(S_IDLE, F_NONE, 6'd0));

    // Fill to 17, leave A and read pending, then reset mid-cycle.
    req_a = 1'b1; din_a = 32'hC3;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
    end
    req_a = 1'b0;
    checkOutput("cnt17", dutVec(), expVec(S_WRITE, F_WR | F_GA, 6'd17));
    applyStimulus(1, 1, 1, 32'hD1, 32'hD2);
    checkOutput("pend_setup", dutVec(), expVec(S_WRITE, F_WR | F_GB, 6'd18));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_vec", dutVec(), expVec(S_IDLE, F_NONE, 6'd0));
    checkOutput("async_rst_din", fifo_din, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    idleCycle();
    checkOutput("post_rst_1", dutVec(), expVec(S_IDLE, F_NONE, 6'd0));
    idleCycle();
    checkOutput("post_rst_2", dutVec(), expVec(S_IDLE, F_NONE, 6'd0));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_access_arbiter.md
# fifo_access_arbiter

Sequencer and arbiter in front of the 32-entry output FIFO: accepts write strobes from two producers (A, B) and read strobes from one consumer. It grants at most one FIFO operation per cycle, drives the FIFO write/read enables and write-data mux, and maintains the occupancy count. It also drives the 3-bit FIFO state code consumed by the FIFO status-flag decoder: full, empty, wr_ack, wr_err, rd_ack, rd_err.

## Interface
- DATA_WIDTH, 32, width of producer data and FIFO write data
- DEPTH, 32, FIFO capacity in entries
- CNT_WIDTH, 6, width of data_count (holds 0..DEPTH)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_a  input  1  producer A write strobe; din_a held stable until gnt_a or err_a
- din_a  input  DATA_WIDTH  producer A write data
- req_b  input  1  producer B write strobe; din_b held stable until gnt_b or err_b
- din_b  input  DATA_WIDTH  producer B write data
- rd_req  input  1  consumer read strobe
- fifo_wr_en  output  1  registered FIFO write enable
- fifo_rd_en  output  1  registered FIFO read enable
- fifo_din  output  DATA_WIDTH  registered write data (muxed din_a/din_b)
- state  output  3  IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100
- data_count  output  CNT_WIDTH  current occupancy
- gnt_a, gnt_b  output  1  one-cycle write grant to A / B
- err_a, err_b  output  1  one-cycle write-error (FIFO full) to A / B
- rd_gnt  output  1  one-cycle read grant
- rd_err  output  1  one-cycle read-error (FIFO empty)

## Operation
- Pending bits pend_a, pend_b, pend_r; effective request: eff_x = req_x | pend_x. A strobe while the bit is already pending is absorbed, with no second operation.
- Legal write: data_count < DEPTH. Legal read: data_count > 0.
- Writer choice is round-robin between A and B via pointer last_w. With both eff, grant the one not equal to last_w; last_w updates on each write grant or write error.
- Read vs write, both eff and legal: grant per toggle rw_pri (0 = write first). rw_pri flips only when such a conflict is resolved.
- Legal operation always beats an error. An error is reported only when no legal operation exists that cycle:
  - Write chosen while full → WR_ERROR, err to the selected writer, pend cleared.
  - Read while empty with no legal write → RD_ERROR, rd_err, pend_r cleared.
- Losing requests set or keep their pend bit.
- Arbitration outcome, registered at the edge:
  - WRITE: fifo_wr_en=1, fifo_din=selected din, gnt_x=1, data_count+1.
  - READ: fifo_rd_en=1, rd_gnt=1, data_count−1.
  - No eff request: IDLE, all strobes 0.
- data_count never leaves 0..DEPTH; increment and decrement never occur in the same cycle.

## Timing
- Reset (asynchronous, any time, including mid-burst) clears the following to 0: state=IDLE, data_count, all pend bits, last_w, rw_pri, fifo_wr_en, fifo_rd_en, fifo_din, and all gnt/err outputs.
- Latency: strobe sampled at edge N → gnt/err/enable high during cycle N+1, for exactly one cycle.
- state, enables and count update together; data_count in cycle N+1 already reflects the operation.
- Back-to-back: one operation per cycle sustained. A strobe arriving in the cycle its grant is high is a new request.
- state returns to IDLE the cycle after any operation with no eff request.

## Test plan
- Reset, then req_a=1 for 1 cycle with din_a=0xA5 → next cycle state=001, gnt_a=1, fifo_wr_en=1, fifo_din=0xA5, data_count=1.
- req_a and req_b same cycle, empty FIFO → gnt_a at cycle 1, gnt_b at cycle 2 (pending), data_count=2. Repeat → B granted first.
- Fill to 32, then req_b → state=011, err_b=1, count stays 32. With pending rd_req in the same cycle → READ granted instead, no error.
- rd_req at count=0 → state=100, rd_err=1, count stays 0.
- Count=5, req_a and rd_req together twice → READ then WRITE order alternates via rw_pri; final count=5.
- Assert reset mid-stream with count=17 and pends set → all outputs 0 immediately, no grants after release until new strobes.
